// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side handshake bundle for the operand stage.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface alu_operand_stage_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;

  logic            in_valid;
  logic            in_ready;
  logic [RIDX-1:0] in_rs1;
  logic [RIDX-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic            in_use_imm;
  logic [3:0]      in_alu_op;
  logic [1:0]      in_btype;
  logic [RIDX-1:0] in_rd;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_alu_op;
  logic [1:0]      out_btype;
  logic [XLEN-1:0] out_in_1;
  logic [XLEN-1:0] out_in_2;
  logic [RIDX-1:0] out_rd;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_alu_op, in_btype, in_rd,
    output in_ready,
    output out_valid, out_alu_op, out_btype, out_in_1, out_in_2, out_rd,
    input  out_ready
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_imm, in_use_imm, in_alu_op, in_btype, in_rd,
    input  in_ready,
    input  out_valid, out_alu_op, out_btype, out_in_1, out_in_2, out_rd,
    output out_ready
  );
endinterface

// File: rtl/alu_operand_stage.sv
// Operand fetch stage: register file with writeback bypass feeding a one-deep
// registered skid-free output slot toward the ALU.
module alu_operand_stage #(
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_operand_stage_if.slave  bus,
  input  logic                wb_en,
  input  logic [4:0]          wb_rd,
  input  logic [31:0]         wb_data,
  output logic [31:0]         accept_count
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned RIDX = 5;
  localparam int unsigned SP_IDX = 2;

  logic [XLEN-1:0] regs [NREG];
  logic [XLEN-1:0] rs1_val_c;
  logic [XLEN-1:0] rs2_val_c;
  logic            accept_c;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready;

  // Source reads see a same-cycle writeback; x0 is hardwired to zero.
  always_comb begin
    rs1_val_c = '0;
    rs2_val_c = '0;
    if (bus.in_rs1 != RIDX'(0))
      rs1_val_c = (wb_en && (wb_rd == bus.in_rs1)) ? wb_data : regs[bus.in_rs1];
    if (bus.in_rs2 != RIDX'(0))
      rs2_val_c = (wb_en && (wb_rd == bus.in_rs2)) ? wb_data : regs[bus.in_rs2];
  end

  // Register file; writeback is independent of the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++)
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else if (wb_en && (wb_rd != RIDX'(0))) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Output slot: operands frozen at accept, replaced on simultaneous drain+accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_alu_op <= '0;
      bus.out_btype  <= '0;
      bus.out_in_1   <= '0;
      bus.out_in_2   <= '0;
      bus.out_rd     <= '0;
      accept_count   <= '0;
    end else begin
      if (accept_c) begin
        bus.out_valid  <= 1'b1;
        bus.out_alu_op <= bus.in_alu_op;
        bus.out_btype  <= bus.in_btype;
        bus.out_in_1   <= rs1_val_c;
        bus.out_in_2   <= bus.in_use_imm ? bus.in_imm : rs2_val_c;
        bus.out_rd     <= bus.in_rd;
        accept_count   <= accept_count + XLEN'(1);
      end else if (bus.out_ready) begin
        bus.out_valid  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed checks of alu_operand_stage against a transaction-level model.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] accept_count;

  int n_pass = 0;
  int n_total = 0;

  // Reference state: architectural registers plus the op the ALU should currently see.
  logic [31:0] mregs [32];
  logic        m_valid;
  logic [3:0]  m_op;
  logic [1:0]  m_bt;
  logic [31:0] m_in1, m_in2, m_count;
  logic [4:0]  m_rd;

  alu_operand_stage_if bus();

  alu_operand_stage #(.SP_INIT(32'h0000_2ffc)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .accept_count(accept_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_en && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mregs[2] = 32'h0000_2ffc;
    m_valid = 1'b0; m_op = '0; m_bt = '0; m_in1 = '0; m_in2 = '0; m_rd = '0; m_count = '0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.in_use_imm = 1'b0; bus.in_alu_op = '0; bus.in_btype = '0; bus.in_rd = '0;
    bus.out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic op(input logic [4:0] rs1, input logic [4:0] rs2, input logic use_imm,
                    input logic [31:0] imm, input logic [3:0] aop, input logic [1:0] bt,
                    input logic [4:0] rd);
    bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_use_imm = use_imm;
    bus.in_imm = imm; bus.in_alu_op = aop; bus.in_btype = bt; bus.in_rd = rd;
  endtask

  // Advance one clock; the model applies the handshake and writeback rules at the edge.
  task automatic tick();
    logic [31:0] v1, v2;
    logic acc;
    v1  = mread(bus.in_rs1);
    v2  = bus.in_use_imm ? bus.in_imm : mread(bus.in_rs2);
    acc = bus.in_valid && (!m_valid || bus.out_ready);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1; m_op = bus.in_alu_op; m_bt = bus.in_btype;
      m_in1 = v1; m_in2 = v2; m_rd = bus.in_rd; m_count = m_count + 32'd1;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    if (wb_en && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (accept_count !== 32'h0) $display("FAIL reset_count: got %h want 0", accept_count); else n_pass++;
    n_total++; if ({bus.out_in_1, bus.out_in_2, bus.out_alu_op, bus.out_btype, bus.out_rd} !== 75'h0)
      $display("FAIL reset_fields: got %h %h %h %h %h want 0", bus.out_in_1, bus.out_in_2, bus.out_alu_op, bus.out_btype, bus.out_rd);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_sp_init();
    op(5'd2, 5'd0, 1'b0, 32'h0, 4'b0000, 2'b00, 5'd1);
    tick();
    idle();
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL sp_valid: got %b want 1", bus.out_valid); else n_pass++;
    n_total++; if (bus.out_in_1 !== 32'h2ffc) $display("FAIL sp_in_1: got %h want 00002ffc", bus.out_in_1); else n_pass++;
    n_total++; if (bus.out_in_2 !== 32'h0) $display("FAIL sp_in_2: got %h want 0", bus.out_in_2); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    op(5'd5, 5'd0, 1'b0, 32'h0, 4'b0001, 2'b00, 5'd3);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    tick();
    n_total++; if (bus.out_in_1 !== 32'h1234) $display("FAIL bypass_in_1: got %h want 00001234", bus.out_in_1); else n_pass++;
    op(5'd0, 5'd0, 1'b0, 32'h0, 4'b0001, 2'b00, 5'd3);
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    n_total++; if (bus.out_in_1 !== 32'h0) $display("FAIL x0_bypass: got %h want 0", bus.out_in_1); else n_pass++;
    wb_en = 1'b0;
    tick();
    n_total++; if (bus.out_in_1 !== 32'h0 || bus.out_in_2 !== 32'h0)
      $display("FAIL x0_write: got %h %h want 0 0", bus.out_in_1, bus.out_in_2);
    else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] cnt;
    op(5'd5, 5'd5, 1'b0, 32'h0, 4'b0010, 2'b01, 5'd7);
    tick();
    cnt = accept_count;
    n_total++; if (bus.out_in_1 !== 32'h1234) $display("FAIL stall_capture: got %h want 00001234", bus.out_in_1); else n_pass++;
    bus.out_ready = 1'b0;
    op(5'd6, 5'd6, 1'b0, 32'h0, 4'b0011, 2'b10, 5'd8);
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 32'hAAAA;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++; if (bus.out_in_1 !== 32'h1234) $display("FAIL stall_hold_%0d: got %h want 00001234", c, bus.out_in_1); else n_pass++;
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready_%0d: got %b want 0", c, bus.in_ready); else n_pass++;
      n_total++; if (accept_count !== cnt) $display("FAIL stall_count_%0d: got %0d want %0d", c, accept_count, cnt); else n_pass++;
      n_total++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd7)
        $display("FAIL stall_fields_%0d: got v=%b rd=%0d want v=1 rd=7", c, bus.out_valid, bus.out_rd);
      else n_pass++;
    end
    idle();
    tick();
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL stall_drain: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      op(5'(c + 1), 5'd2, 1'b0, 32'h0, 4'(c), 2'(c), 5'(c + 9));
      tick();
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL b2b_valid_%0d: got %b want 1", c, bus.out_valid); else n_pass++;
      n_total++; if (bus.out_alu_op !== 4'(c) || bus.out_in_2 !== 32'h2ffc)
        $display("FAIL b2b_fields_%0d: got op=%h in2=%h want op=%h in2=00002ffc", c, bus.out_alu_op, bus.out_in_2, c);
      else n_pass++;
    end
    n_total++; if (accept_count !== 32'd4) $display("FAIL b2b_count: got %0d want 4", accept_count); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_passthru();
    op(5'd0, 5'd2, 1'b1, 32'hFFFF_FFF0, 4'b1111, 2'b11, 5'd31);
    tick();
    n_total++; if (bus.out_in_2 !== 32'hFFFF_FFF0) $display("FAIL imm_in_2: got %h want fffffff0", bus.out_in_2); else n_pass++;
    n_total++; if (bus.out_alu_op !== 4'b1111 || bus.out_btype !== 2'b11 || bus.out_rd !== 5'd31)
      $display("FAIL passthru: got op=%b bt=%b rd=%0d want 1111 11 31", bus.out_alu_op, bus.out_btype, bus.out_rd);
    else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 3) != 0);
      bus.in_rs1 = 5'($urandom); bus.in_rs2 = 5'($urandom);
      bus.in_imm = $urandom; bus.in_use_imm = 1'($urandom);
      bus.in_alu_op = 4'($urandom); bus.in_btype = 2'($urandom); bus.in_rd = 5'($urandom);
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      wb_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      n_total++; if (bus.in_ready !== (!m_valid || bus.out_ready))
        $display("FAIL rnd_in_ready_%0d: got %b want %b", c, bus.in_ready, !m_valid || bus.out_ready);
      else n_pass++;
      tick();
      n_total++; if (bus.out_valid !== m_valid || accept_count !== m_count)
        $display("FAIL rnd_state_%0d: got v=%b cnt=%0d want v=%b cnt=%0d", c, bus.out_valid, accept_count, m_valid, m_count);
      else n_pass++;
      if (m_valid) begin
        n_total++;
        if ({bus.out_in_1, bus.out_in_2, bus.out_alu_op, bus.out_btype, bus.out_rd} !== {m_in1, m_in2, m_op, m_bt, m_rd})
          $display("FAIL rnd_fields_%0d: got %h %h %h %h %h want %h %h %h %h %h", c,
                   bus.out_in_1, bus.out_in_2, bus.out_alu_op, bus.out_btype, bus.out_rd,
                   m_in1, m_in2, m_op, m_bt, m_rd);
        else n_pass++;
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_stall();
    op(5'd2, 5'd0, 1'b0, 32'h0, 4'b0100, 2'b00, 5'd4);
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_total++; if (bus.out_valid !== 1'b1) $display("FAIL mid_stall_setup: got %b want 1", bus.out_valid); else n_pass++;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (bus.out_valid !== 1'b0 || accept_count !== 32'h0 || bus.out_in_1 !== 32'h0)
      $display("FAIL mid_stall_reset: got v=%b cnt=%0d in1=%h want 0 0 0", bus.out_valid, accept_count, bus.out_in_1);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_stall_ready: got %b want 1", bus.in_ready); else n_pass++;
    op(5'd2, 5'd0, 1'b0, 32'h0, 4'b0000, 2'b00, 5'd1);
    tick();
    n_total++; if (bus.out_in_1 !== 32'h2ffc || accept_count !== 32'd1)
      $display("FAIL mid_stall_sp: got in1=%h cnt=%0d want 00002ffc 1", bus.out_in_1, accept_count);
    else n_pass++;
    idle();
    tick();
  endtask

  initial begin
    reset_n = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_sp_init();
    test_bypass();
    test_stall();
    test_back_to_back();
    test_passthru();
    test_random();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 Parameter SP_INIT, default 32'h0000_2ffc, SHALL be the reset value of register x2.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  upstream decode presents an operation.
REQ-006 in_ready  output  1  block accepts the operation this cycle.
REQ-007 in_rs1, in_rs2  input  5 each  source register indices.
REQ-008 in_imm  input  32  sign-extended immediate.
REQ-009 in_use_imm  input  1  select in_imm instead of rs2 value for operand B.
REQ-010 in_alu_op  input  4  ALU operation code; in_btype input 2 branch type; in_rd input 5 destination index.
REQ-011 wb_en  input  1  writeback enable; wb_rd input 5 index; wb_data input 32 value.
REQ-012 out_valid  output  1  operands valid toward ALU; out_ready input 1 ALU stage accepts.
REQ-013 out_alu_op output 4, out_btype output 2, out_in_1 output 32, out_in_2 output 32, out_rd output 5: registered ALU-side fields.
REQ-014 accept_count  output  32  number of accepted operations.

Function
REQ-015 The block SHALL hold a 32 x 32-bit register file; x0 SHALL read as 0 at all times.
REQ-016 On a rising edge with wb_en=1 and wb_rd!=0, reg[wb_rd] SHALL take wb_data; writes to x0 SHALL be discarded.
REQ-017 Source reads SHALL bypass: if wb_en=1, wb_rd==rsN and rsN!=0 in the same cycle, the read value SHALL be wb_data, else reg[rsN].
REQ-018 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-019 Accept = in_valid && in_ready; on accept the output register SHALL capture out_in_1=rs1 value, out_in_2=(in_use_imm ? in_imm : rs2 value), alu_op, btype and rd at the rising edge; latency 1 cycle.
REQ-020 out_valid SHALL set on accept, clear on (out_valid && out_ready && !accept), hold otherwise.
REQ-021 Simultaneous out handshake and accept SHALL replace the output contents with no bubble (full throughput).
REQ-022 While out_valid=1 and out_ready=0, all out_* fields SHALL remain stable, including when wb writes the captured source registers (operands frozen at accept).
REQ-023 The block SHALL pass in_alu_op and in_btype unmodified, including codes the ALU treats as default.
REQ-024 The block SHALL apply no arithmetic to operands; all widths SHALL be exactly 32 bits, with no truncation or extension.
REQ-025 accept_count SHALL increment by 1 per accept and wrap from 32'hFFFF_FFFF to 0.
REQ-026 Writeback SHALL proceed independently of handshake state, including while stalled.

Reset
REQ-027 While reset_n=0, out_valid SHALL be 0 and all out_* fields and accept_count SHALL be 0, asynchronously.
REQ-028 Reset SHALL set every register to 0 except x2=SP_INIT.
REQ-029 Reset asserted mid-stall SHALL drop the held operation without handshake; in_ready SHALL be 1 once reset_n=1.
REQ-030 The first accept SHALL occur no earlier than the first rising edge after reset_n deasserts.

Verification
REQ-031 Reset release, rs1=2, rs2=0, use_imm=0, alu_op=4'b0000, out_ready=1 -> next cycle out_valid=1, out_in_1=32'h2ffc, out_in_2=0.
REQ-032 wb_en=1, wb_rd=5, wb_data=32'h1234 in the same cycle as accept with rs1=5 -> out_in_1=32'h1234 (bypass); wb_rd=0 with data 32'hFFFF -> x0 still reads 0.
REQ-033 out_ready=0 for 3 cycles after accept of rs1=5, while wb writes x5=32'hAAAA -> out_in_1 holds 32'h1234, in_ready=0, accept_count unchanged.
REQ-034 in_valid=1 and out_ready=1 for 4 consecutive cycles -> 4 accepts, out_valid continuously 1, accept_count=4.
REQ-035 use_imm=1, in_imm=32'hFFFF_FFF0, rs2=2 -> out_in_2=32'hFFFF_FFF0; alu_op=4'b1111, btype=2'b11 passed unchanged.
REQ-036 reset_n pulsed low while out_valid=1 and out_ready=0 -> out_valid=0 immediately, x2=32'h2ffc, accept_count=0.
